// File: rtl/ptp_rtc_gen2.sv
// PTPv2 real-time counter, second generation.
// Seconds + ns + fractional-ns clock advanced by tick_inc_i every cycle.
// Supports absolute load, exact offset correction with a busy handshake,
// and a phase/width programmable PPS output.
module ptp_rtc_gen2 #(
  parameter int          FNS_W = 26,
  parameter int          SC_W  = 48,
  parameter logic [31:0] SC2NS = 32'd1000000000
) (
  input  logic                   rtc_clk,
  input  logic                   rtc_rst_n,
  input  logic [31:0]            tick_inc_i,
  input  logic                   clear_rtc_i,
  input  logic                   set_time_i,
  input  logic [SC_W-1:0]        set_sc_i,
  input  logic [31:0]            set_ns_i,
  input  logic                   offset_valid_i,
  input  logic signed [31:0]     ns_offset_i,
  input  logic signed [SC_W-1:0] sc_offset_i,
  input  logic [31:0]            pps_phase_i,
  input  logic [31:0]            pps_width_i,
  output logic                   offset_busy_o,
  output logic [SC_W+31:0]       current_time_o,
  output logic [15:0]            rtc_fns_o,
  output logic                   pps_o,
  output logic                   sec_tick_o
);

  localparam int            NW      = 32 + FNS_W;
  localparam logic [NW-1:0] SEC_FNS = {SC2NS, {FNS_W{1'b0}}};

  logic [NW-1:0]   ns_q;
  logic [SC_W-1:0] sc_q;
  logic [2:0]      clr_sync;
  logic            set_pend_q;
  logic [SC_W-1:0] set_sc_q;
  logic [31:0]     set_ns_q;
  logic [1:0]      off_pipe;    // [0]: captured, [1]: apply at next edge
  logic [31:0]     ns_off_q;
  logic [SC_W-1:0] sc_off_q;
  logic            sec_evt_q;
  logic            sec_tick_q;
  logic            pps_q;

  logic            clr_rise;
  logic [NW-1:0]   ns_sum, ns_trj;
  logic            trj_wrap;
  logic [SC_W-1:0] sc_trj;
  logic [33:0]     ofs_sum, ofs_ns;
  logic            ofs_neg, ofs_ovf, ofs_evt;
  logic [SC_W-1:0] ofs_adj, ofs_sc;
  logic [31:0]     ns_int;
  logic [32:0]     pps_end;
  logic            pps_win;

  assign clr_rise = clr_sync[1] & ~clr_sync[2];

  // Free-running trajectory: one tick with single-cycle second wrap.
  always_comb begin
    ns_sum   = ns_q + {{(NW-32){1'b0}}, tick_inc_i};
    trj_wrap = ns_sum[NW-1:FNS_W] >= SC2NS;
    ns_trj   = trj_wrap ? ns_sum - SEC_FNS : ns_sum;
    sc_trj   = sc_q + {{(SC_W-1){1'b0}}, trj_wrap};
  end

  // Offset applied on top of the trajectory; fraction bits pass untouched.
  always_comb begin
    ofs_sum = {2'b00, ns_trj[NW-1:FNS_W]} + {{2{ns_off_q[31]}}, ns_off_q};
    ofs_neg = ofs_sum[33];
    ofs_ovf = !ofs_neg && (ofs_sum[32:0] >= {1'b0, SC2NS});
    ofs_ns  = ofs_sum;
    ofs_adj = '0;
    if (ofs_neg) begin
      ofs_ns  = ofs_sum + {2'b00, SC2NS};
      ofs_adj = '1;
    end else if (ofs_ovf) begin
      ofs_ns  = ofs_sum - {2'b00, SC2NS};
      ofs_adj = {{(SC_W-1){1'b0}}, 1'b1};
    end
    ofs_sc  = sc_trj + sc_off_q + ofs_adj;
    // Net one-second move from wrap and normalisation combined.
    ofs_evt = ofs_ovf | (trj_wrap ^ ofs_neg);
  end

  // PPS window on the current ns, wrapping modulo one second.
  always_comb begin
    ns_int  = ns_q[NW-1:FNS_W];
    pps_end = {1'b0, pps_phase_i} + {1'b0, pps_width_i};
    if (pps_end <= {1'b0, SC2NS})
      pps_win = (ns_int >= pps_phase_i) && ({1'b0, ns_int} < pps_end);
    else
      pps_win = (ns_int >= pps_phase_i) || ({1'b0, ns_int} < pps_end - {1'b0, SC2NS});
  end

  // Clear synchroniser with rising-edge history flop.
  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) clr_sync <= '0;
    else            clr_sync <= {clr_sync[1:0], clear_rtc_i};
  end

  // Time state: clear > set > offset apply > tick; offset request capture.
  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) begin
      ns_q       <= '0;
      sc_q       <= '0;
      set_pend_q <= 1'b0;
      set_sc_q   <= '0;
      set_ns_q   <= '0;
      off_pipe   <= '0;
      ns_off_q   <= '0;
      sc_off_q   <= '0;
      sec_evt_q  <= 1'b0;
    end else begin
      set_pend_q <= set_time_i;
      set_sc_q   <= set_sc_i;
      set_ns_q   <= set_ns_i;
      sec_evt_q  <= 1'b0;
      if (clr_rise) begin
        ns_q     <= '0;
        sc_q     <= '0;
        off_pipe <= '0;
      end else if (set_pend_q) begin
        ns_q     <= {set_ns_q, {FNS_W{1'b0}}};
        sc_q     <= set_sc_q;
        off_pipe <= '0;
      end else if (off_pipe[1]) begin
        ns_q      <= {ofs_ns[31:0], ns_trj[FNS_W-1:0]};
        sc_q      <= ofs_sc;
        sec_evt_q <= ofs_evt;
        off_pipe  <= '0;
      end else begin
        ns_q      <= ns_trj;
        sc_q      <= sc_trj;
        sec_evt_q <= trj_wrap;
        off_pipe  <= {off_pipe[0], 1'b0};
        if (off_pipe == 2'b00 && offset_valid_i) begin
          off_pipe <= 2'b01;
          ns_off_q <= ns_offset_i;
          sc_off_q <= sc_offset_i;
        end
      end
    end
  end

  // Status outputs, one cycle behind the time they describe.
  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) begin
      pps_q      <= 1'b0;
      sec_tick_q <= 1'b0;
    end else begin
      pps_q      <= pps_win;
      sec_tick_q <= sec_evt_q;
    end
  end

  assign current_time_o = {sc_q, ns_q[NW-1:FNS_W]};
  assign rtc_fns_o      = ns_q[FNS_W-1:FNS_W-16];
  assign offset_busy_o  = |off_pipe;
  assign pps_o          = pps_q;
  assign sec_tick_o     = sec_tick_q;

endmodule

// File: tb/tb_ptp_rtc_gen2.sv
// Scoreboard bench for ptp_rtc_gen2: expectations are queued with the edge
// index at which they must hold and checked just after that edge.
module tb_ptp_rtc_gen2;
  localparam int FNS_W = 26;
  localparam int SC_W  = 48;
  localparam int K_TIME = 0, K_BUSY = 1, K_PPS = 2, K_STK = 3, K_FNS = 4;

  logic                   rtc_clk = 1'b0;
  logic                   rtc_rst_n = 1'b0;
  logic [31:0]            tick_inc_i = 32'h2000_0000;
  logic                   clear_rtc_i = 1'b0;
  logic                   set_time_i = 1'b0;
  logic [SC_W-1:0]        set_sc_i = '0;
  logic [31:0]            set_ns_i = '0;
  logic                   offset_valid_i = 1'b0;
  logic signed [31:0]     ns_offset_i = '0;
  logic signed [SC_W-1:0] sc_offset_i = '0;
  logic [31:0]            pps_phase_i = '0;
  logic [31:0]            pps_width_i = '0;
  logic                   offset_busy_o;
  logic [SC_W+31:0]       current_time_o;
  logic [15:0]            rtc_fns_o;
  logic                   pps_o;
  logic                   sec_tick_o;

  ptp_rtc_gen2 #(.FNS_W(FNS_W), .SC_W(SC_W), .SC2NS(32'd1000000000)) dut (
    .rtc_clk(rtc_clk), .rtc_rst_n(rtc_rst_n), .tick_inc_i(tick_inc_i),
    .clear_rtc_i(clear_rtc_i), .set_time_i(set_time_i), .set_sc_i(set_sc_i),
    .set_ns_i(set_ns_i), .offset_valid_i(offset_valid_i),
    .ns_offset_i(ns_offset_i), .sc_offset_i(sc_offset_i),
    .pps_phase_i(pps_phase_i), .pps_width_i(pps_width_i),
    .offset_busy_o(offset_busy_o), .current_time_o(current_time_o),
    .rtc_fns_o(rtc_fns_o), .pps_o(pps_o), .sec_tick_o(sec_tick_o)
  );

  always #5 rtc_clk = ~rtc_clk;

  typedef struct {
    string       tag;
    int          cyc;
    int          kind;
    logic [79:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;

  task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d got %0h want %0h", tag, edge_n, act, exp);
    end
  endtask

  function automatic logic [79:0] tm(input longint s, input longint ns);
    logic [47:0] sv;
    logic [31:0] nv;
    sv = 48'(s);
    nv = 32'(ns);
    return {sv, nv};
  endfunction

  function automatic logic [79:0] observe(input int kind);
    case (kind)
      K_TIME:  return current_time_o;
      K_BUSY:  return {79'd0, offset_busy_o};
      K_PPS:   return {79'd0, pps_o};
      K_STK:   return {79'd0, sec_tick_o};
      default: return {64'd0, rtc_fns_o};
    endcase
  endfunction

  task automatic push(input string tag, input int cyc, input int kind, input logic [79:0] exp);
    exp_t e;
    e.tag = tag; e.cyc = cyc; e.kind = kind; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == edge_n) begin
        chk(sb[i].tag, observe(sb[i].kind), sb[i].exp);
        sb.delete(i);
      end else if (sb[i].cyc < edge_n) begin
        chk({sb[i].tag, "_missed"}, 80'd1, 80'd0);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge rtc_clk);
      #1;
      edge_n++;
      drain();
    end
  endtask

  task automatic drive_set(input longint s, input longint ns);
    set_sc_i   = 48'(s);
    set_ns_i   = 32'(ns);
    set_time_i = 1'b1;
  endtask

  initial begin
    int s, a, k, c, r;

    // Reset state
    repeat (3) @(posedge rtc_clk);
    #1;
    push("rst_time", 0, K_TIME, tm(0, 0));
    push("rst_busy", 0, K_BUSY, 80'd0);
    push("rst_pps",  0, K_PPS,  80'd0);
    push("rst_stk",  0, K_STK,  80'd0);
    push("rst_fns",  0, K_FNS,  80'd0);
    drain();
    rtc_rst_n = 1'b1;

    // 8 ns ticks from zero
    push("tick1",   1,   K_TIME, tm(0, 8));
    push("tick125", 125, K_TIME, tm(0, 1000));
    push("pps_w0",  125, K_PPS,  80'd0);
    step(125);

    // Set near a second boundary, then natural wrap
    s = edge_n + 1;
    push("set_load", s + 1, K_TIME, tm(5, 999_999_992));
    push("set_wrap", s + 2, K_TIME, tm(6, 0));
    push("stk_set",  s + 2, K_STK,  80'd0);
    push("stk_wrap", s + 3, K_STK,  80'd1);
    push("stk_one",  s + 4, K_STK,  80'd0);
    drive_set(5, 999_999_992);
    step(1); set_time_i = 1'b0;
    step(4);

    // Negative offset crossing back over a second, second request ignored
    s = edge_n + 1; a = s + 1; k = a + 2;
    push("ofs1_set",   a,     K_TIME, tm(6, 999_999_984));
    push("ofs1_busy0", k,     K_BUSY, 80'd1);
    push("ofs1_busy1", k + 1, K_BUSY, 80'd1);
    push("ofs1_busy2", k + 2, K_BUSY, 80'd0);
    push("ofs1_busy3", k + 3, K_BUSY, 80'd0);
    push("ofs1_stkw",  k + 1, K_STK,  80'd1);
    push("ofs1_stk0",  k + 2, K_STK,  80'd0);
    push("ofs1_stkn",  k + 3, K_STK,  80'd1);
    push("ofs1_res",   k + 2, K_TIME, tm(6, 999_999_996));
    push("ofs1_next",  k + 3, K_TIME, tm(7, 4));
    drive_set(6, 999_999_984);
    step(1); set_time_i = 1'b0;
    step(2);
    ns_offset_i = -32'sd20; sc_offset_i = '0; offset_valid_i = 1'b1;
    step(1);
    ns_offset_i = 32'sd500;
    step(1); offset_valid_i = 1'b0;
    step(4);

    // Positive offset with seconds part, 6.4 ns tick, fraction preserved
    s = edge_n + 1; a = s + 1; k = a + 1;
    push("ofs2_set",   a,     K_TIME, tm(7, 999_999_941));
    push("ofs2_fns0",  a,     K_FNS,  80'd0);
    push("ofs2_res",   k + 2, K_TIME, tm(11, 60));
    push("ofs2_fns",   k + 2, K_FNS,  80'h3333);
    push("ofs2_next",  k + 3, K_TIME, tm(11, 66));
    push("ofs2_fnsn",  k + 3, K_FNS,  80'h9999);
    push("ofs2_stk",   k + 3, K_STK,  80'd1);
    tick_inc_i = 32'h1999_999A;
    drive_set(7, 999_999_941);
    step(1); set_time_i = 1'b0;
    step(1);
    ns_offset_i = 32'sd100; sc_offset_i = 48'sd3; offset_valid_i = 1'b1;
    step(1); offset_valid_i = 1'b0;
    step(4);

    // PPS inside one second
    tick_inc_i = 32'h2000_0000;
    pps_phase_i = 32'd100; pps_width_i = 32'd40;
    s = edge_n + 1; a = s + 1;
    push("pps_pre", a + 13, K_PPS, 80'd0);
    for (int j = 14; j <= 18; j++) push($sformatf("pps_hi%0d", j), a + j, K_PPS, 80'd1);
    push("pps_post", a + 19, K_PPS, 80'd0);
    drive_set(20, 0);
    step(1); set_time_i = 1'b0;
    step(20);

    // PPS straddling the second
    pps_phase_i = 32'd999_999_980; pps_width_i = 32'd40;
    s = edge_n + 1; a = s + 1;
    push("ppsw_pre", a + 3, K_PPS, 80'd0);
    for (int j = 4; j <= 8; j++) push($sformatf("ppsw_hi%0d", j), a + j, K_PPS, 80'd1);
    push("ppsw_post", a + 9, K_PPS, 80'd0);
    drive_set(30, 999_999_960);
    step(1); set_time_i = 1'b0;
    step(10);

    // Set in the same cycle as an offset request: set wins, busy drops
    k = edge_n + 1;
    push("sov_busy0", k,     K_BUSY, 80'd1);
    push("sov_busy1", k + 1, K_BUSY, 80'd0);
    push("sov_load",  k + 1, K_TIME, tm(40, 0));
    push("sov_next",  k + 2, K_TIME, tm(40, 8));
    push("sov_more",  k + 3, K_TIME, tm(40, 16));
    drive_set(40, 0);
    ns_offset_i = -32'sd20; sc_offset_i = '0; offset_valid_i = 1'b1;
    step(1); set_time_i = 1'b0; offset_valid_i = 1'b0;
    step(4);

    // Offset with natural wrap at k+1 and negative seconds offset
    s = edge_n + 1; a = s + 1; k = a + 1;
    push("ofs3_res",  k + 2, K_TIME, tm(60, 3));
    push("ofs3_stkw", k + 2, K_STK,  80'd1);
    push("ofs3_stkn", k + 3, K_STK,  80'd1);
    push("ofs3_next", k + 3, K_TIME, tm(60, 11));
    drive_set(60, 999_999_984);
    step(1); set_time_i = 1'b0;
    step(1);
    ns_offset_i = 32'sd999_999_995; sc_offset_i = -48'sd2; offset_valid_i = 1'b1;
    step(1); offset_valid_i = 1'b0;
    step(4);

    // Clear beats a set applying on the same edge; held level clears once
    c = edge_n + 1;
    push("clr_zero", c + 2,  K_TIME, tm(0, 0));
    push("clr_tick", c + 3,  K_TIME, tm(0, 8));
    push("clr_stk",  c + 3,  K_STK,  80'd0);
    push("clr_held", c + 10, K_TIME, tm(0, 64));
    clear_rtc_i = 1'b1;
    step(1);
    drive_set(50, 100);
    step(1); set_time_i = 1'b0;
    step(8);
    clear_rtc_i = 1'b0;
    step(3);
    r = edge_n + 1;
    push("clr_again", r + 2, K_TIME, tm(0, 0));
    clear_rtc_i = 1'b1;
    step(1); clear_rtc_i = 1'b0;
    step(3);

    while (sb.size() != 0) begin
      chk({sb[0].tag, "_never"}, 80'd1, 80'd0);
      void'(sb.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
